// File: rtl/cpu_defs.sv
// cpu_defs: shared writeback-select encodings and register-file constants.
package cpu_defs;
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_DM   = 2'd1,
        WB_LINK = 2'd2,
        WB_HILO = 2'd3
    } wb_sel_e;
    localparam logic [4:0]  REG_ZERO       = 5'd0;
    localparam logic [31:0] PC_LINK_OFFSET = 32'd8;
endpackage

// File: rtl/grf_core.sv
// grf_core: register storage with async active-low clear, one write port, two raw read ports.
//   clk, reset (active-low async clear), we/wa/wd write port, ra1/ra2 -> rd1/rd2 raw reads.
module grf_core
    import cpu_defs::*;
#(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [31:0]   wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [31:0]   rd1,
    output logic [31:0]   rd2
);
    logic [31:0] mem [NREG];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end
    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
endmodule

// File: rtl/w_wb_grf.sv
// w_wb_grf: W-stage writeback mux, register file with W->D bypass, commit trace and write counter.
//   clk, reset (async active-low); W_* writeback inputs; D_A1/D_A2 -> D_RD1/D_RD2 combinational reads;
//   W_WD selected writeback data; trace_* registered record of the last cycle's commit; wr_count commits.
module w_wb_grf
    import cpu_defs::*;
#(
    parameter int          NREG      = 32,
    parameter logic [31:0] PC_OFFSET = PC_LINK_OFFSET,
    localparam int         AW        = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   W_PC,
    input  logic          W_RegWrite,
    input  logic [1:0]    W_MemtoReg,
    input  logic [AW-1:0] W_A3,
    input  logic [31:0]   W_ALU_C,
    input  logic [31:0]   W_HILO,
    input  logic [31:0]   W_DM_RD,
    input  logic [AW-1:0] D_A1,
    input  logic [AW-1:0] D_A2,
    output logic [31:0]   D_RD1,
    output logic [31:0]   D_RD2,
    output logic [31:0]   W_WD,
    output logic          trace_valid,
    output logic [31:0]   trace_pc,
    output logic [AW-1:0] trace_a3,
    output logic [31:0]   trace_wd,
    output logic [31:0]   wr_count
);
    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);
    logic        commit;
    logic [31:0] raw1, raw2;
    assign commit = W_RegWrite && W_A3 != ZERO;
    always_comb begin
        W_WD = W_MemtoReg == WB_DM   ? W_DM_RD :
               W_MemtoReg == WB_LINK ? W_PC + PC_OFFSET :
               W_MemtoReg == WB_HILO ? W_HILO : W_ALU_C;
    end
    grf_core #(.NREG(NREG), .AW(AW)) u_core (
        .clk (clk),
        .reset (reset),
        .we  (commit),
        .wa  (W_A3),
        .wd  (W_WD),
        .ra1 (D_A1),
        .ra2 (D_A2),
        .rd1 (raw1),
        .rd2 (raw2)
    );
    // Reads are forced to zero while reset is held so a pending bypass cannot leak out.
    assign D_RD1 = (!reset || D_A1 == ZERO) ? '0 : (commit && D_A1 == W_A3) ? W_WD : raw1;
    assign D_RD2 = (!reset || D_A2 == ZERO) ? '0 : (commit && D_A2 == W_A3) ? W_WD : raw2;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_a3    <= '0;
            trace_wd    <= '0;
            wr_count    <= '0;
        end else begin
            trace_valid <= commit;
            if (commit) begin
                trace_pc <= W_PC;
                trace_a3 <= W_A3;
                trace_wd <= W_WD;
                wr_count <= wr_count + 32'd1;
            end
        end
    end
endmodule
